// File: rtl/ifu_fetch_if.sv
// Handshake bundle between the PC stage, instruction memory, decode and the fetch unit.
// master is the fetch unit's view; slave is the surrounding pipeline/memory view.
`timescale 1ns/1ps
interface ifu_fetch_if;
   logic        ifu_rx_valid;
   logic        ifu_rx_ready;
   logic [31:0] ifu_rx_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        ifu_tx_valid;
   logic        ifu_tx_ready;
   logic [31:0] ifu_tx_pc;
   logic [31:0] ifu_tx_inst;
   logic        ifu_tx_misalign;
   logic [31:0] ifu_fetch_cnt;

   modport master (
      input  ifu_rx_valid, ifu_rx_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, ifu_tx_ready,
      output ifu_rx_ready, imem_req_valid, imem_req_addr, ifu_tx_valid, ifu_tx_pc, ifu_tx_inst,
             ifu_tx_misalign, ifu_fetch_cnt
   );

   modport slave (
      output ifu_rx_valid, ifu_rx_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, ifu_tx_ready,
      input  ifu_rx_ready, imem_req_valid, imem_req_addr, ifu_tx_valid, ifu_tx_pc, ifu_tx_inst,
             ifu_tx_misalign, ifu_fetch_cnt
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: takes one PC, issues a single-beat imem read, presents {pc, inst}
// to decode. Misaligned PCs bypass memory and carry a NOP with a misalign flag.
`timescale 1ns/1ps
module ifu_fetch #(
   parameter logic [31:0] NOP_INST  = 32'h0000_0013,
   parameter logic [31:0] RESET_CNT = 32'd0
) (
   input logic          clk,
   input logic          rstn,
   ifu_fetch_if.master  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] cnt_q;
   logic        tx_valid_q;
   logic        misalign_q;
   logic        rx_ready;
   logic        rx_ena;
   logic        tx_ena;
   logic        req_ena;
   logic        rx_pc_mis;

   assign tx_ena    = tx_valid_q && bus.ifu_tx_ready;
   assign req_ena   = (state == S_REQ) && bus.imem_req_ready;
   assign rx_ena    = bus.ifu_rx_valid && rx_ready;
   assign rx_pc_mis = (bus.ifu_rx_pc[1:0] != 2'b00);

   // Holding state accepts a new PC only in the cycle decode takes the current one.
   always_comb begin
      rx_ready = 1'b0;
      case (state)
         S_IDLE:  rx_ready = rstn;
         S_HOLD:  rx_ready = tx_ena;
         default: rx_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         pc_q       <= '0;
         inst_q     <= '0;
         tx_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         cnt_q      <= RESET_CNT;
      end else begin
         if (tx_ena)
            cnt_q <= cnt_q + 32'd1;

         // rx_ena can only fire in S_IDLE or S_HOLD, so the accept path is shared by both.
         if (rx_ena) begin
            pc_q <= bus.ifu_rx_pc;
            if (rx_pc_mis) begin
               state      <= S_HOLD;
               tx_valid_q <= 1'b1;
               inst_q     <= NOP_INST;
               misalign_q <= 1'b1;
            end else begin
               state      <= S_REQ;
               tx_valid_q <= 1'b0;
               misalign_q <= 1'b0;
            end
         end else begin
            case (state)
               S_REQ: begin
                  if (req_ena)
                     state <= S_WAIT;
               end
               S_WAIT: begin
                  if (bus.imem_rsp_valid) begin
                     inst_q     <= bus.imem_rsp_data;
                     tx_valid_q <= 1'b1;
                     state      <= S_HOLD;
                  end
               end
               S_HOLD: begin
                  if (tx_ena) begin
                     tx_valid_q <= 1'b0;
                     state      <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.ifu_rx_ready    = rx_ready;
   assign bus.imem_req_valid  = (state == S_REQ);
   assign bus.imem_req_addr   = pc_q;
   assign bus.ifu_tx_valid    = tx_valid_q;
   assign bus.ifu_tx_pc       = pc_q;
   assign bus.ifu_tx_inst     = inst_q;
   assign bus.ifu_tx_misalign = misalign_q;
   assign bus.ifu_fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: table of fetch records driven through a scoreboard,
// plus hand sequences for mid-fetch reset and counter wrap.
`timescale 1ns/1ps
module tb_ifu_fetch;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   ifu_fetch_if bus();
   ifu_fetch_if wbus();

   ifu_fetch #(.NOP_INST(32'h0000_0013), .RESET_CNT(32'd0)) u_dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   ifu_fetch #(.NOP_INST(32'h0000_0013), .RESET_CNT(32'hFFFF_FFFE)) u_wrap (
      .clk (clk),
      .rstn(rstn),
      .bus (wbus)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int unsigned mem_stall;
      int unsigned tx_stall;
      bit          chain;
      logic [31:0] exp_inst;
      logic        exp_mis;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        mis;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_cnt = 32'd0;
   logic [31:0] wexp;
   vec_t        tbl[10];
   vec_t        rst_v;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Present a PC and record what decode should later receive for it.
   task automatic offer(input vec_t v);
      bus.ifu_rx_valid = 1'b1;
      bus.ifu_rx_pc    = v.pc;
      #1;
      chk("rx_ready_offer", {31'd0, bus.ifu_rx_ready}, 32'd1);
      sb.push_back('{v.pc, v.exp_inst, v.exp_mis});
   endtask

   task automatic run_rec(input vec_t v, input bit pre, input vec_t nv);
      exp_t e;
      if (!pre) begin
         offer(v);
         tick();
         bus.ifu_rx_valid = 1'b0;
      end
      if (v.pc[1:0] == 2'b00) begin
         chk("req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
         chk("req_addr", bus.imem_req_addr, v.pc);
         chk("rx_ready_req", {31'd0, bus.ifu_rx_ready}, 32'd0);
         chk("tx_valid_req", {31'd0, bus.ifu_tx_valid}, 32'd0);
         for (int i = 0; i < int'(v.mem_stall); i++) begin
            bus.imem_req_ready = 1'b0;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
            tick();
            chk("req_valid_stall", {31'd0, bus.imem_req_valid}, 32'd1);
            chk("req_addr_stall", bus.imem_req_addr, v.pc);
            chk("rx_ready_stall", {31'd0, bus.ifu_rx_ready}, 32'd0);
         end
         bus.imem_req_ready = 1'b1;
         bus.imem_rsp_valid = (v.mem_stall != 0);
         bus.imem_rsp_data  = 32'hDEAD_BEEF;
         tick();
         bus.imem_req_ready = 1'b0;
         bus.imem_rsp_valid = 1'b0;
         chk("req_valid_wait", {31'd0, bus.imem_req_valid}, 32'd0);
         chk("tx_valid_wait", {31'd0, bus.ifu_tx_valid}, 32'd0);
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data  = v.data;
         tick();
         bus.imem_rsp_valid = 1'b0;
      end else begin
         chk("req_valid_mis", {31'd0, bus.imem_req_valid}, 32'd0);
      end
      chk("tx_valid", {31'd0, bus.ifu_tx_valid}, 32'd1);

      for (int i = 0; i < int'(v.tx_stall); i++) begin
         bus.ifu_tx_ready = 1'b0;
         bus.ifu_rx_valid = 1'b1;
         bus.ifu_rx_pc    = 32'h0000_BAD1;
         tick();
         chk("tx_valid_stall", {31'd0, bus.ifu_tx_valid}, 32'd1);
         chk("tx_pc_stall", bus.ifu_tx_pc, v.pc);
         chk("tx_inst_stall", bus.ifu_tx_inst, v.exp_inst);
         chk("rx_ready_stall", {31'd0, bus.ifu_rx_ready}, 32'd0);
      end
      bus.ifu_rx_valid = 1'b0;

      bus.ifu_tx_ready = 1'b1;
      if (v.chain) begin
         offer(nv);
      end else begin
         #1;
         chk("rx_ready_tx", {31'd0, bus.ifu_rx_ready}, 32'd1);
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_empty: got output with no expected entry at %0t", $time);
      end else begin
         e = sb.pop_front();
         chk("tx_pc", bus.ifu_tx_pc, e.pc);
         chk("tx_inst", bus.ifu_tx_inst, e.inst);
         chk("tx_misalign", {31'd0, bus.ifu_tx_misalign}, {31'd0, e.mis});
      end
      tick();
      exp_cnt++;
      bus.ifu_tx_ready = 1'b0;
      bus.ifu_rx_valid = 1'b0;
      chk("fetch_cnt", bus.ifu_fetch_cnt, exp_cnt);
      if (!v.chain) begin
         chk("tx_valid_done", {31'd0, bus.ifu_tx_valid}, 32'd0);
         chk("req_valid_idle", {31'd0, bus.imem_req_valid}, 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{32'h0000_0100, 32'h00A0_0093, 0, 0, 1'b0, 32'h00A0_0093, 1'b0};
      tbl[1] = '{32'h0000_0200, 32'h0050_0113, 4, 0, 1'b0, 32'h0050_0113, 1'b0};
      tbl[2] = '{32'h0000_0300, 32'h0020_81B3, 0, 5, 1'b1, 32'h0020_81B3, 1'b0};
      tbl[3] = '{32'h0000_0104, 32'h40B5_0533, 0, 0, 1'b0, 32'h40B5_0533, 1'b0};
      tbl[4] = '{32'h0000_0102, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_0013, 1'b1};
      tbl[5] = '{32'h0000_0108, 32'h0000_0297, 0, 0, 1'b0, 32'h0000_0297, 1'b0};
      tbl[6] = '{32'h0000_010B, 32'h0000_0000, 0, 2, 1'b1, 32'h0000_0013, 1'b1};
      tbl[7] = '{32'h0000_010D, 32'h0000_0000, 0, 0, 1'b1, 32'h0000_0013, 1'b1};
      tbl[8] = '{32'h0000_0110, 32'hFFFF_FFFF, 2, 1, 1'b0, 32'hFFFF_FFFF, 1'b0};
      tbl[9] = '{32'hFFFF_FFFC, 32'h1234_5678, 0, 0, 1'b0, 32'h1234_5678, 1'b0};

      bus.ifu_rx_valid = 1'b0;  bus.ifu_rx_pc = '0;
      bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
      bus.ifu_tx_ready = 1'b0;
      wbus.ifu_rx_valid = 1'b0; wbus.ifu_rx_pc = '0;
      wbus.imem_req_ready = 1'b0; wbus.imem_rsp_valid = 1'b0; wbus.imem_rsp_data = '0;
      wbus.ifu_tx_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_rx_ready", {31'd0, bus.ifu_rx_ready}, 32'd0);
      chk("rst_tx_valid", {31'd0, bus.ifu_tx_valid}, 32'd0);
      chk("rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("rst_req_addr", bus.imem_req_addr, 32'd0);
      chk("rst_tx_pc", bus.ifu_tx_pc, 32'd0);
      chk("rst_tx_inst", bus.ifu_tx_inst, 32'd0);
      chk("rst_misalign", {31'd0, bus.ifu_tx_misalign}, 32'd0);
      chk("rst_cnt", bus.ifu_fetch_cnt, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) begin
         if (i + 1 < 10)
            run_rec(tbl[i], (i > 0) && tbl[(i > 0) ? i - 1 : 0].chain, tbl[i + 1]);
         else
            run_rec(tbl[i], (i > 0) && tbl[i - 1].chain, tbl[i]);
      end

      // Reset while waiting on memory; the late response must be dropped.
      rst_v = '{32'h0000_0400, 32'h0000_0000, 0, 0, 1'b0, 32'h0000_0000, 1'b0};
      offer(rst_v);
      tick();
      bus.ifu_rx_valid   = 1'b0;
      bus.imem_req_ready = 1'b1;
      tick();
      bus.imem_req_ready = 1'b0;
      chk("mid_tx_valid", {31'd0, bus.ifu_tx_valid}, 32'd0);
      rstn = 1'b0;
      #1;
      chk("mid_rst_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("mid_rst_rx_ready", {31'd0, bus.ifu_rx_ready}, 32'd0);
      chk("mid_rst_addr", bus.imem_req_addr, 32'd0);
      chk("mid_rst_tx_inst", bus.ifu_tx_inst, 32'd0);
      chk("mid_rst_cnt", bus.ifu_fetch_cnt, 32'd0);
      sb.delete();
      exp_cnt = 32'd0;
      tick();
      tick();
      rstn = 1'b1;
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
      tick();
      bus.imem_rsp_valid = 1'b0;
      chk("late_rsp_tx_valid", {31'd0, bus.ifu_tx_valid}, 32'd0);
      chk("late_rsp_rx_ready", {31'd0, bus.ifu_rx_ready}, 32'd1);
      chk("late_rsp_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
      chk("late_rsp_cnt", bus.ifu_fetch_cnt, 32'd0);
      tick();
      chk("late_rsp_tx_valid2", {31'd0, bus.ifu_tx_valid}, 32'd0);
      rst_v = '{32'h0000_0500, 32'h0010_0073, 1, 0, 1'b0, 32'h0010_0073, 1'b0};
      run_rec(rst_v, 1'b0, rst_v);

      // Counter wrap on the second instance using misaligned entries.
      wexp = 32'hFFFF_FFFE;
      chk("wrap_rst_cnt", wbus.ifu_fetch_cnt, wexp);
      for (int k = 0; k < 2; k++) begin
         wbus.ifu_rx_valid = 1'b1;
         wbus.ifu_rx_pc    = 32'h0000_0006;
         tick();
         wbus.ifu_rx_valid = 1'b0;
         chk("wrap_tx_valid", {31'd0, wbus.ifu_tx_valid}, 32'd1);
         chk("wrap_tx_inst", wbus.ifu_tx_inst, 32'h0000_0013);
         chk("wrap_misalign", {31'd0, wbus.ifu_tx_misalign}, 32'd1);
         wbus.ifu_tx_ready = 1'b1;
         tick();
         wbus.ifu_tx_ready = 1'b0;
         wexp = wexp + 32'd1;
         chk("wrap_cnt", wbus.ifu_fetch_cnt, wexp);
      end
      chk("wrap_cnt_zero", wbus.ifu_fetch_cnt, 32'd0);

      chk("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit sitting directly downstream of the PC register stage. It accepts one PC per valid/ready handshake and issues a single-beat read to instruction memory. It captures the returned word and presents {pc, inst} to the decode stage over a valid/ready handshake. Misaligned PCs are flagged and never reach memory; a 32-bit counter records delivered fetches.

Parameters:
NOP_INST, 32'h0000_0013, instruction word emitted alongside a misalign flag (addi x0,x0,0)
RESET_CNT, 32'd0, reset value of the fetch counter

Ports:
clk  input  1  clock; all state updates on rising edge
rstn  input  1  asynchronous, active-low reset
ifu_rx_valid  input  1  PC stage offers a PC
ifu_rx_ready  output  1  fetch unit accepts PC (combinational)
ifu_rx_pc  input  32  PC to fetch
imem_req_valid  output  1  read request to instruction memory (combinational from state)
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned read address (registered PC)
imem_rsp_valid  input  1  read data valid, single beat
imem_rsp_data  input  32  read data
ifu_tx_valid  output  1  fetched instruction available to decode (registered)
ifu_tx_ready  input  1  decode accepts instruction
ifu_tx_pc  output  32  PC of presented instruction
ifu_tx_inst  output  32  presented instruction word
ifu_tx_misalign  output  1  presented PC had pc[1:0] != 0
ifu_fetch_cnt  output  32  count of completed tx handshakes

Behaviour:
- Handshake: a transfer occurs only in a cycle where valid && ready are both high. rx_ena = ifu_rx_valid && ifu_rx_ready; tx_ena = ifu_tx_valid && ifu_tx_ready; req_ena = imem_req_valid && imem_req_ready.
- Reset values: state=S_IDLE; ifu_tx_valid=0; ifu_tx_pc=0; ifu_tx_inst=0; ifu_tx_misalign=0; imem_req_addr=0; ifu_fetch_cnt=RESET_CNT. ifu_rx_ready=0 while rstn=0.
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD (2-bit encoding).
- S_IDLE: ifu_rx_ready=rstn. On rx_ena, latch ifu_rx_pc into pc_q (drives imem_req_addr and ifu_tx_pc).
  - If pc[1:0]!=0: next state S_HOLD; tx_valid<=1, inst<=NOP_INST, misalign<=1.
  - Otherwise: next state S_REQ, misalign<=0.
- S_REQ: imem_req_valid=1 and imem_req_addr held stable until req_ena; ifu_rx_ready=0. On req_ena -> S_WAIT.
- S_WAIT: ifu_rx_ready=0, imem_req_valid=0. On imem_rsp_valid: inst<=imem_rsp_data, tx_valid<=1 -> S_HOLD.
- S_HOLD: ifu_tx_valid=1; tx_pc, tx_inst and tx_misalign are held stable until tx_ena. ifu_rx_ready=tx_ena, giving a back-to-back path.
  - tx_ena && rx_ena: the new PC is latched with the same aligned/misaligned split as S_IDLE (misaligned -> remain S_HOLD with the new NOP entry; aligned -> S_REQ, tx_valid<=0).
  - tx_ena only: -> S_IDLE, tx_valid<=0.
  - Neither: stay in S_HOLD.
- imem_rsp_valid outside S_WAIT is ignored, including in the req_ena cycle. Memory returns data at least one cycle after req_ena.
- Latency (aligned PC, memory ready, 1-cycle response): rx_ena at cycle N; imem_req_valid at N+1; rsp at N+2; ifu_tx_valid at N+3.
- ifu_fetch_cnt increments by 1 on every tx_ena, including misaligned entries. It wraps 32'hFFFF_FFFF -> 0 with no flag.
- Reset asserted mid-operation: all state and outputs return to reset values immediately. An in-flight memory response arriving after release lands in S_IDLE and is dropped.
- At most one fetch is outstanding; the block never issues a second request before the response.

Test Plan:
- Single fetch: rx_pc=0x0000_0100, imem_req_ready=1, rsp one cycle after request with data 0x00A0_0093, tx_ready=1 -> imem_req_addr=0x100, tx_valid exactly 3 cycles after rx_ena with tx_pc=0x100, tx_inst=0x00A0_0093, misalign=0, fetch_cnt=1.
- Memory backpressure: imem_req_ready low for 4 cycles -> imem_req_valid stays high with addr stable and rx_ready=0 throughout; completes normally afterwards; a spurious imem_rsp_valid during S_REQ is ignored.
- Decode stall plus back-to-back: tx_ready=0 for 5 cycles -> tx_pc/tx_inst stable and rx_ready=0; then tx_ready=1 with rx_valid=1 and pc=0x104 -> same-cycle accept, next request addr=0x104.
- Misaligned: rx_pc=0x0000_0102 -> no imem_req_valid, next cycle tx_valid=1, tx_inst=0x0000_0013, misalign=1; a following aligned PC fetches normally with misalign=0.
- Reset mid-fetch: assert rstn low in S_WAIT, release, then drive rsp_valid with 0xDEAD_BEEF -> tx_valid stays 0, state S_IDLE, fetch_cnt=RESET_CNT.
- Counter wrap: RESET_CNT=32'hFFFF_FFFE, two completed fetches -> ifu_fetch_cnt=0.
